xpb_table_gen: RTL and testbench
================================

# xpb_table_gen

Runtime-built, parametrised successor to the fixed XPB lookup ROMs used by the modular-square datapath. Given a digit-weight value `base = 2^k mod N` and the modulus `N`, it computes the 2^DIGIT_BITS multiples `j*base mod N` sequentially, one entry per cycle, and stores them. Once built, it serves registered lookups by digit value. A new modulus or weight can be loaded without regenerating RTL.

## Interface
- DIGIT_BITS, 5: lookup digit width; the table has 2^DIGIT_BITS entries.
- WORD_BITS, 1024: modulus and entry width.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  one-cycle pulse that latches base and modulus and begins a build.
- base  in  WORD_BITS  digit weight; must satisfy base < modulus.
- modulus  in  WORD_BITS  N; must be nonzero.
- busy  out  1  high while building.
- ready  out  1  table valid; lookups accepted.
- err  out  1  last start was rejected.
- lookup_valid  in  1  lookup request.
- data_in  in  DIGIT_BITS  digit to look up.
- out_valid  out  1  data_out holds a fresh result.
- data_out  out  WORD_BITS  table[data_in] = data_in*base mod N.

## Operation
- The FSM has three states: IDLE, BUILD, READY. On reset it is IDLE with busy=0, ready=0, err=0, out_valid=0, data_out=0 and counter=0. Table contents are not cleared.
- start in IDLE or READY checks the operands:
  - If modulus==0 or base>=modulus: set err=1, set ready=0, go to IDLE. No build runs.
  - Otherwise: clear err, latch base_r and mod_r, write table[0]=0, set acc=0 and cnt=1, then go to BUILD.
- BUILD, each cycle:
  - Compute sum = acc + base_r at WORD_BITS+1 bits.
  - Compute nxt = (sum >= mod_r) ? sum - mod_r : sum. Because both operands are below N, one conditional subtract is sufficient.
  - Write table[cnt]=nxt, set acc=nxt, increment cnt.
  - After writing entry 2^DIGIT_BITS-1, go to READY.
- start during BUILD is ignored. base and modulus are don't-care except in the start cycle.
- Lookups:
  - In READY, lookup_valid registers data_out=table[data_in] and out_valid=1 on the next edge.
  - Outside READY, lookup_valid is ignored: out_valid=0 and data_out holds its value.
  - out_valid is a one-cycle pulse per accepted request. Back-to-back requests give back-to-back results.
- start in READY drops ready on the same edge. An in-flight lookup issued in that same cycle is dropped (out_valid=0).

## Timing
- start is sampled at edge E0. busy=1 and ready=0 are visible from E0.
- Entry j is written at edge E0+j, for j=1..2^D-1.
- ready=1 and busy=0 are visible after edge E0+2^D-1. The build takes 31 cycles at the defaults.
- Lookup latency is 1 cycle and throughput is 1 per cycle.
- err is set at E0 for a rejected start.
- rst_n=0 in any state, including mid-BUILD, returns to the reset values at the next edge. A later start performs a full rebuild.
- Critical path is the WORD_BITS-wide add followed by the compare/subtract. A pipeline stage may be inserted there only if the build latency is updated accordingly; lookup latency must remain 1.

## Structure
- Package `xpb_pkg` holds:
  - the state enum (IDLE, BUILD, READY);
  - the default DIGIT_BITS and WORD_BITS localparams;
  - a helper for the table depth (1<<DIGIT_BITS).
- Sub-module `xpb_modadd` (parameter WORD_BITS) is combinational: inputs a, b, n; output (a+b) mod n for a,b<n. It is reused by the accumulator trees that consume these tables.
- Table storage is a register array of 2^DIGIT_BITS × WORD_BITS bits, with one write port (build) and one read port (lookup).

## Test plan
- DIGIT_BITS=2, WORD_BITS=8, modulus=13, base=5, start -> busy for 3 cycles, then ready. Lookups 0,1,2,3 return 0,5,10,2, each one cycle after request.
- Same configuration, start with base=13, modulus=13 -> err=1, ready=0. A lookup of 1 gives out_valid=0.
- From READY, start with base=7, modulus=11 -> ready drops at start. After 3 cycles, lookups 0..3 return 0,7,3,10.
- Assert rst_n=0 mid-BUILD (after entry 1) -> all outputs return to reset values. A new start with base=3, modulus=13 yields 0,3,6,9.
- Defaults (5/1024), modulus=2^1024-1, base=2^1023 -> ready after 31 cycles. Lookup 2 returns 1, lookup 31 returns a golden-model value. Back-to-back lookups 0..31 produce 32 consecutive out_valid pulses.
- lookup_valid held high during BUILD -> no out_valid until the first requested cycle after ready rises.

Source files
------------

// File: rtl/xpb_pkg.sv
// Shared types and defaults for the runtime-built XPB multiple table.
package xpb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUILD = 2'd1,
        READY = 2'd2
    } xpb_state_e;

    localparam int DIGIT_BITS_DEF = 5;
    localparam int WORD_BITS_DEF  = 1024;

    function automatic int table_depth(input int digit_bits);
        return 1 << digit_bits;
    endfunction

endpackage

// File: rtl/xpb_modadd.sv
// Modular adder: (a + b) mod n, valid when both a and b are already below n.
module xpb_modadd #(
    parameter int WORD_BITS = 1024
) (
    input  logic [WORD_BITS-1:0] a,
    input  logic [WORD_BITS-1:0] b,
    input  logic [WORD_BITS-1:0] n,
    output logic [WORD_BITS-1:0] sum
);

    logic [WORD_BITS:0] raw;
    logic [WORD_BITS:0] n_ext;

    assign raw   = {1'b0, a} + {1'b0, b};
    assign n_ext = {1'b0, n};

    // a + b < 2n, so a single conditional subtract lands in [0, n).
    assign sum = (raw >= n_ext) ? WORD_BITS'(raw - n_ext) : WORD_BITS'(raw);

endmodule

// File: rtl/xpb_table_gen.sv
// Builds table[j] = j*base mod N one entry per cycle, then serves registered lookups.
module xpb_table_gen
    import xpb_pkg::*;
#(
    parameter int DIGIT_BITS = DIGIT_BITS_DEF,
    parameter int WORD_BITS  = WORD_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_BITS-1:0]  base,
    input  logic [WORD_BITS-1:0]  modulus,
    output logic                  busy,
    output logic                  ready,
    output logic                  err,
    input  logic                  lookup_valid,
    input  logic [DIGIT_BITS-1:0] data_in,
    output logic                  out_valid,
    output logic [WORD_BITS-1:0]  data_out
);

    localparam int                    DEPTH    = table_depth(DIGIT_BITS);
    localparam logic [DIGIT_BITS-1:0] LAST_IDX = DIGIT_BITS'(DEPTH - 1);

    xpb_state_e            state, state_next;
    logic [WORD_BITS-1:0]  base_r, mod_r, acc, nxt;
    logic [DIGIT_BITS-1:0] cnt;
    logic [WORD_BITS-1:0]  table_mem [DEPTH];

    logic                  operands_ok, start_take;
    logic                  wr_en;
    logic [DIGIT_BITS-1:0] wr_addr;
    logic [WORD_BITS-1:0]  wr_data;

    assign operands_ok = (modulus != '0) && (base < modulus);
    assign start_take  = start && (state != BUILD);
    assign busy        = (state == BUILD);
    assign ready       = (state == READY);

    xpb_modadd #(.WORD_BITS(WORD_BITS)) u_modadd (
        .a   (acc),
        .b   (base_r),
        .n   (mod_r),
        .sum (nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, READY: if (start) state_next = operands_ok ? BUILD : IDLE;
            BUILD:       if (cnt == LAST_IDX) state_next = READY;
            default:     state_next = IDLE;
        endcase
    end

    // Single write port: entry 0 on an accepted start, entry cnt while building.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        if (start_take && operands_ok) begin
            wr_en = 1'b1;
        end else if (state == BUILD) begin
            wr_en   = 1'b1;
            wr_addr = cnt;
            wr_data = nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) table_mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err       <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= 1'b0;
            // A start in READY invalidates the table, so a same-cycle lookup is dropped.
            if (state == READY && lookup_valid && !start) begin
                out_valid <= 1'b1;
                data_out  <= table_mem[data_in];
            end
            if (start_take) begin
                if (operands_ok) begin
                    err    <= 1'b0;
                    base_r <= base;
                    mod_r  <= modulus;
                    acc    <= '0;
                    cnt    <= DIGIT_BITS'(1);
                end else begin
                    err <= 1'b1;
                end
            end else if (state == BUILD) begin
                acc <= nxt;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench: a 2/8 instance and a default 5/1024 instance against a j*base mod N model.
module tb_xpb_table_gen;

    logic        clk;
    logic        rst_n;
    logic        start_v [2];
    logic [1023:0] base_v [2];
    logic [1023:0] mod_v  [2];
    logic        lv_v    [2];
    logic [4:0]  din_v   [2];
    logic        busy_v  [2];
    logic        ready_v [2];
    logic        err_v   [2];
    logic        ov_v    [2];
    logic [1023:0] dout_v [2];
    logic [7:0]  dout_s;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    xpb_table_gen #(.DIGIT_BITS(2), .WORD_BITS(8)) dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_v[0]),
        .base         (base_v[0][7:0]),
        .modulus      (mod_v[0][7:0]),
        .busy         (busy_v[0]),
        .ready        (ready_v[0]),
        .err          (err_v[0]),
        .lookup_valid (lv_v[0]),
        .data_in      (din_v[0][1:0]),
        .out_valid    (ov_v[0]),
        .data_out     (dout_s)
    );

    xpb_table_gen dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start_v[1]),
        .base         (base_v[1]),
        .modulus      (mod_v[1]),
        .busy         (busy_v[1]),
        .ready        (ready_v[1]),
        .err          (err_v[1]),
        .lookup_valid (lv_v[1]),
        .data_in      (din_v[1]),
        .out_valid    (ov_v[1]),
        .data_out     (dout_v[1])
    );

    assign dout_v[0] = {1016'b0, dout_s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got(lo)=%0h want(lo)=%0h", name, act[191:0], exp[191:0]);
        end
    endtask

    // Model: phase 0=idle 1=build 2=ready; table computed straight from j*base mod N.
    int            m_phase [2];
    int            m_left  [2];
    logic          m_err   [2];
    logic          m_ov    [2];
    logic [1023:0] m_do    [2];
    logic [1023:0] m_tab   [2][32];

    function automatic int dep(input int d);
        return (d == 0) ? 4 : 32;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_phase[d] = 0; m_left[d] = 0; m_err[d] = 1'b0;
                m_ov[d] = 1'b0; m_do[d] = '0;
            end else begin
                m_ov[d] = 1'b0;
                if (m_phase[d] == 2 && lv_v[d] && !start_v[d]) begin
                    m_ov[d] = 1'b1;
                    m_do[d] = m_tab[d][int'(din_v[d]) % dep(d)];
                end
                if (start_v[d] && m_phase[d] != 1) begin
                    if (mod_v[d] == '0 || base_v[d] >= mod_v[d]) begin
                        m_err[d] = 1'b1; m_phase[d] = 0;
                    end else begin
                        m_err[d] = 1'b0; m_phase[d] = 1; m_left[d] = dep(d) - 1;
                        for (int j = 0; j < dep(d); j++) begin
                            logic [1039:0] p;
                            logic [1039:0] r;
                            p = {16'b0, base_v[d]} * 1040'(j);
                            r = p % {16'b0, mod_v[d]};
                            m_tab[d][j] = r[1023:0];
                        end
                    end
                end else if (m_phase[d] == 1) begin
                    m_left[d]--;
                    if (m_left[d] == 0) m_phase[d] = 2;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy%0d", d),  1024'(busy_v[d]),  1024'(m_phase[d] == 1));
                chk($sformatf("ready%0d", d), 1024'(ready_v[d]), 1024'(m_phase[d] == 2));
                chk($sformatf("err%0d", d),   1024'(err_v[d]),   1024'(m_err[d]));
                chk($sformatf("ov%0d", d),    1024'(ov_v[d]),    1024'(m_ov[d]));
                chk($sformatf("dout%0d", d),  dout_v[d],         m_do[d]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int d, input logic [1023:0] b, input logic [1023:0] m);
        start_v[d] = 1'b1; base_v[d] = b; mod_v[d] = m;
        tick();
        start_v[d] = 1'b0;
    endtask

    // Called right after the start edge; counts visible busy cycles until ready.
    task automatic wait_ready(input int d, output int nbusy);
        int guard;
        nbusy = 0;
        guard = 0;
        while (!ready_v[d] && guard < 100) begin
            if (busy_v[d]) nbusy++;
            tick();
            guard++;
        end
        if (guard >= 100) chk("ready_timeout", 1024'(ready_v[d]), 1024'(1));
    endtask

    task automatic lookup(input int d, input int j, input logic [1023:0] exp, input string nm);
        lv_v[d] = 1'b1; din_v[d] = 5'(j);
        tick();
        lv_v[d] = 1'b0;
        chk({nm, "_v"}, 1024'(ov_v[d]), 1024'(1));
        chk({nm, "_d"}, dout_v[d], exp);
    endtask

    initial begin
        int nb;
        int pulses;
        logic [1023:0] b_big, m_big, v31;
        b_big = 1024'(1) << 1023;
        m_big = '1;
        v31   = b_big + 1024'(15);
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0; base_v[d] = '0; mod_v[d] = '0; lv_v[d] = 1'b0; din_v[d] = '0;
        end
        tick(); tick();
        rst_n = 1'b1;
        chk_en = 1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 1024'(busy_v[d]), 1024'(0));
            chk("rst_ready", 1024'(ready_v[d]), 1024'(0));
            chk("rst_err", 1024'(err_v[d]), 1024'(0));
            chk("rst_ov", 1024'(ov_v[d]), 1024'(0));
            chk("rst_dout", dout_v[d], 1024'(0));
        end

        // N=13, base=5
        do_start(0, 1024'(5), 1024'(13));
        wait_ready(0, nb);
        chk("s_busy_cycles", 1024'(nb), 1024'(3));
        lookup(0, 0, 1024'(0), "s5_0");
        lookup(0, 1, 1024'(5), "s5_1");
        lookup(0, 2, 1024'(10), "s5_2");
        lookup(0, 3, 1024'(2), "s5_3");

        // base == modulus is rejected
        do_start(0, 1024'(13), 1024'(13));
        chk("rej_err", 1024'(err_v[0]), 1024'(1));
        chk("rej_ready", 1024'(ready_v[0]), 1024'(0));
        lv_v[0] = 1'b1; din_v[0] = 5'd1;
        tick();
        lv_v[0] = 1'b0;
        chk("rej_lookup_ov", 1024'(ov_v[0]), 1024'(0));
        do_start(0, 1024'(3), 1024'(0));
        chk("zero_mod_err", 1024'(err_v[0]), 1024'(1));

        // Restart from READY with a same-cycle lookup that must be dropped
        do_start(0, 1024'(5), 1024'(13));
        wait_ready(0, nb);
        chk("err_cleared", 1024'(err_v[0]), 1024'(0));
        lv_v[0] = 1'b1; din_v[0] = 5'd1;
        do_start(0, 1024'(7), 1024'(11));
        lv_v[0] = 1'b0;
        chk("restart_ready_drop", 1024'(ready_v[0]), 1024'(0));
        chk("restart_ov_drop", 1024'(ov_v[0]), 1024'(0));
        wait_ready(0, nb);
        chk("restart_busy_cycles", 1024'(nb), 1024'(3));
        lookup(0, 0, 1024'(0), "s7_0");
        lookup(0, 1, 1024'(7), "s7_1");
        lookup(0, 2, 1024'(3), "s7_2");
        lookup(0, 3, 1024'(10), "s7_3");

        // Reset mid-build, then full rebuild
        do_start(0, 1024'(5), 1024'(13));
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_busy", 1024'(busy_v[0]), 1024'(0));
        chk("mid_rst_ready", 1024'(ready_v[0]), 1024'(0));
        chk("mid_rst_dout", dout_v[0], 1024'(0));
        do_start(0, 1024'(3), 1024'(13));
        wait_ready(0, nb);
        lookup(0, 0, 1024'(0), "s3_0");
        lookup(0, 1, 1024'(3), "s3_1");
        lookup(0, 2, 1024'(6), "s3_2");
        lookup(0, 3, 1024'(9), "s3_3");

        // Default size: N = 2^1024-1, base = 2^1023
        do_start(1, b_big, m_big);
        wait_ready(1, nb);
        chk("b_busy_cycles", 1024'(nb), 1024'(31));
        lookup(1, 2, 1024'(1), "b_2");
        lookup(1, 31, v31, "b_31");
        chk("model_pin_31", m_tab[1][31], v31);
        pulses = 0;
        for (int j = 0; j < 32; j++) begin
            lv_v[1] = 1'b1; din_v[1] = 5'(j);
            tick();
            if (ov_v[1]) pulses++;
        end
        lv_v[1] = 1'b0;
        tick();
        chk("b2b_pulses", 1024'(pulses), 1024'(32));
        chk("b2b_tail_ov", 1024'(ov_v[1]), 1024'(0));

        // lookup_valid held through a build
        lv_v[0] = 1'b1; din_v[0] = 5'd2;
        do_start(0, 1024'(5), 1024'(13));
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            if (ov_v[0]) pulses++;
            tick();
        end
        chk("hold_ready_rose", 1024'(ready_v[0]), 1024'(1));
        chk("hold_no_early_ov", 1024'(pulses + int'(ov_v[0])), 1024'(0));
        tick();
        lv_v[0] = 1'b0;
        chk("hold_first_ov", 1024'(ov_v[0]), 1024'(1));
        chk("hold_first_data", dout_v[0], 1024'(10));
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
